alu_seq_ctrl: RTL
=================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, number of response FIFO entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req_valid input 1, req_ready output 1  request handshake.
REQ-005 SHALL have ports: req_a input 2, req_b input 2, req_op input 2, req_tag input 2  operands, opcode (00 ADD, 01 SUB, 10 AND, 11 XOR), requester tag.
REQ-006 SHALL have ports: alu_a output 2, alu_b output 2, alu_sel output 2  registered drive to the external combinational 2-bit ALU.
REQ-007 SHALL have ports: alu_result input 2, alu_carry input 1  ALU outputs, sampled by this block.
REQ-008 SHALL have ports: rsp_valid output 1, rsp_ready input 1  response handshake.
REQ-009 SHALL have ports: rsp_result output 2, rsp_carry output 1, rsp_tag output 2  response payload from the FIFO head.
REQ-010 SHALL have port: op_count output 8  completed-operation counter.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, WB; exactly one operation in flight.
REQ-012 SHALL assert req_ready only in IDLE with FIFO occupancy < FIFO_DEPTH.
REQ-013 SHALL accept a request on a rising edge with req_valid && req_ready: latch req_a/req_b/req_op into alu_a/alu_b/alu_sel, latch req_tag internally, IDLE->EXEC.
REQ-014 SHALL hold alu_a/alu_b/alu_sel stable from acceptance until the next acceptance.
REQ-015 SHALL transition EXEC->WB unconditionally after one cycle (ALU settle cycle).
REQ-016 SHALL in WB push {alu_result, alu_carry, tag} into the FIFO on the WB clock edge, increment op_count (mod 256) and return to IDLE.
REQ-017 SHALL produce rsp_valid exactly 3 rising edges after the accepting edge when the FIFO was empty.
REQ-018 SHALL pass alu_carry through unmodified for every opcode; the block performs no arithmetic itself.
REQ-019 SHALL drive rsp_valid = FIFO not empty; payload = head entry; pop on rsp_valid && rsp_ready.
REQ-020 SHALL keep payload stable while rsp_valid && !rsp_ready.
REQ-021 SHALL handle simultaneous push and pop in one cycle: occupancy unchanged, order preserved.
REQ-022 SHALL never overflow: a push into a full FIFO is impossible by REQ-012; pop of an empty FIFO is ignored.
REQ-023 SHALL deliver responses in acceptance order (FIFO order).
REQ-024 SHALL ignore req_* inputs when req_ready is low.

Reset
REQ-025 SHALL on rst_n low, immediately: state IDLE, FIFO emptied, pointers 0, op_count 0, alu_a/alu_b/alu_sel 0, rsp_valid 0, req_ready 0 while rst_n low.
REQ-026 SHALL discard any in-flight operation on reset (no response emitted after release).
REQ-027 SHALL assert req_ready on the first rising edge after rst_n deasserts (FIFO empty).

Structure
REQ-028 SHALL place opcode enum (OP_ADD, OP_SUB, OP_AND, OP_XOR), FSM state enum and default FIFO_DEPTH in shared package alu_seq_pkg.
REQ-029 SHALL implement the response buffer as sub-module alu_rsp_fifo (5-bit entries, FIFO_DEPTH deep, count output).

Verification (bench instantiates the team's 2-bit ALU on alu_* ports)
REQ-030 SHALL cover ADD: A=3, B=1, tag=2 -> rsp result=0, carry=1, tag=2, rsp_valid 3 edges after accept.
REQ-031 SHALL cover SUB: A=1, B=2 -> result=3, carry=1; AND: A=3, B=2 -> result=2, carry=0; XOR: A=3, B=1 -> result=2, carry=0.
REQ-032 SHALL cover backpressure: rsp_ready=0, issue 5 requests with FIFO_DEPTH=4 -> 4 accepted, req_ready low, head payload stable; then rsp_ready=1 -> 4 responses in order, 5th accepted.
REQ-033 SHALL cover simultaneous push/pop: FIFO at 2 entries, WB coincides with pop -> occupancy stays 2, order intact.
REQ-034 SHALL cover reset mid-operation: assert rst_n=0 in EXEC -> no response after release, op_count=0, req_ready=1 next edge.
REQ-035 SHALL cover op_count wrap: 256 completed operations -> op_count returns to 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode/state encodings and response entry layout
package alu_seq_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int RSP_W              = 5;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  // Response entry as stored in the FIFO, MSB first: result, carry, tag.
  typedef struct packed {
    logic [1:0] result;
    logic       carry;
    logic [1:0] tag;
  } rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - response buffer with occupancy count
module alu_rsp_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = RSP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  // Guarded so a push into a full FIFO or a pop of an empty one is a no-op.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequences one request at a time through an external 2-bit ALU
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_a,
  input  logic [1:0] req_b,
  input  logic [1:0] req_op,
  input  logic [1:0] req_tag,
  output logic [1:0] alu_a,
  output logic [1:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [1:0] alu_result,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_result,
  output logic       rsp_carry,
  output logic [1:0] rsp_tag,
  output logic [7:0] op_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state;
  logic          run_q;
  logic [1:0]    tag_q;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  rsp_t          push_entry;
  rsp_t          head;

  // run_q keeps req_ready low through reset and for the release edge itself.
  assign req_ready  = run_q && (state == IDLE) && (fifo_count < CW'(FIFO_DEPTH));
  assign accept     = req_valid && req_ready;
  assign push       = (state == WB);
  assign push_entry = '{result: alu_result, carry: alu_carry, tag: tag_q};
  assign rsp_valid  = !fifo_empty;
  assign pop        = rsp_valid && rsp_ready;
  assign rsp_result = head.result;
  assign rsp_carry  = head.carry;
  assign rsp_tag    = head.tag;

  // Enable request acceptance from the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Sequencer: latch operands on accept, one ALU settle cycle, then write back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      tag_q    <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_sel <= req_op;
            tag_q   <= req_tag;
            state   <= EXEC;
          end
        end
        EXEC: state <= WB;
        WB: begin
          op_count <= op_count + 8'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  alu_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RSP_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
